// File: rtl/wb_misc_arbiter_if.sv
// Wishbone pipelined bus bundle; signal directions are named from the slave side
// (dat_i = write data into the slave, dat_o = read data out of the slave).
interface if_wb;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        stall;
    logic        ack;

    modport master (
        output adr, dat_i, sel, we, cyc, stb,
        input  dat_o, stall, ack
    );

    modport slave (
        input  adr, dat_i, sel, we, cyc, stb,
        output dat_o, stall, ack
    );
endinterface

// File: rtl/wb_misc_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one pipelined slave.
// Latches the accepted request and completes stuck cycles with a watchdog.
//
// state  | meaning
// S_IDLE | no owner; accept one request this cycle (round-robin on contention)
// S_REQ  | strobe latched request to the slave until it stops stalling
// S_WAIT | strobe dropped, waiting for slave ack or watchdog expiry
module wb_misc_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    if_wb.slave        m0,
    if_wb.slave        m1,
    if_wb.master       s,
    output logic [1:0] grant,
    output logic       timeout
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_we;

    logic w_req0;
    logic w_req1;
    logic w_sel_valid;
    logic w_sel_idx;
    logic w_own_cyc;
    logic w_abort;
    logic w_done_ack;
    logic w_done_to;
    logic w_done;

    assign w_req0      = m0.cyc & m0.stb;
    assign w_req1      = m1.cyc & m1.stb;
    assign w_sel_valid = w_req0 | w_req1;
    assign w_sel_idx   = (w_req0 & w_req1) ? ~r_last : w_req1;

    // Owner dropping cyc abandons the cycle; it also masks any ack/timeout.
    assign w_own_cyc  = r_grant[1] ? m1.cyc : m0.cyc;
    assign w_abort    = (r_state != S_IDLE) & ~w_own_cyc;
    assign w_done_ack = (r_state == S_WAIT) & ~w_abort & s.ack;
    assign w_done_to  = (r_state == S_WAIT) & ~w_abort & ~s.ack & (r_cnt == CNT_LAST);
    assign w_done     = w_done_ack | w_done_to;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_sel_valid) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_abort)       w_state_nxt = S_IDLE;
                else if (!s.stall) w_state_nxt = S_WAIT;
            end
            S_WAIT: if (w_abort || w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
            r_adr   <= 32'd0;
            r_dat   <= 32'd0;
            r_sel   <= 4'd0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_valid) begin
                        r_adr   <= w_sel_idx ? m1.adr   : m0.adr;
                        r_dat   <= w_sel_idx ? m1.dat_i : m0.dat_i;
                        r_sel   <= w_sel_idx ? m1.sel   : m0.sel;
                        r_we    <= w_sel_idx ? m1.we    : m0.we;
                        r_grant <= w_sel_idx ? 2'b10 : 2'b01;
                        r_last  <= w_sel_idx;
                    end
                end
                S_REQ: begin
                    r_cnt <= 8'd0;
                    if (w_abort) r_grant <= 2'b00;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_state_nxt == S_IDLE) r_grant <= 2'b00;
                end
                default: r_grant <= 2'b00;
            endcase
        end
    end

    assign s.cyc   = ((r_state == S_REQ) | (r_state == S_WAIT)) & ~w_done_to;
    assign s.stb   = (r_state == S_REQ);
    assign s.adr   = r_adr;
    assign s.dat_i = r_dat;
    assign s.sel   = r_sel;
    assign s.we    = r_we;

    assign m0.stall = ~((r_state == S_IDLE) & w_sel_valid & ~w_sel_idx);
    assign m1.stall = ~((r_state == S_IDLE) & w_sel_valid &  w_sel_idx);
    assign m0.ack   = w_done & r_grant[0];
    assign m1.ack   = w_done & r_grant[1];
    assign m0.dat_o = w_done_to ? TO_DATA : s.dat_o;
    assign m1.dat_o = w_done_to ? TO_DATA : s.dat_o;

    assign grant   = r_grant;
    assign timeout = w_done_to;
endmodule

// File: tb/tb_wb_misc_arbiter.sv
// Self-checking bench for wb_misc_arbiter: two bench masters, a misc-I/O style
// slave with configurable stall/ack latency, and a round-robin reference model.
module tb_wb_misc_arbiter;
    localparam logic [31:0] TO_DATA = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout_o;

    if_wb m0_if();
    if_wb m1_if();
    if_wb s_if();

    wb_misc_arbiter #(.TIMEOUT(16), .TO_DATA(TO_DATA)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant   (grant),
        .timeout (timeout_o)
    );

    always #5 clk = ~clk;

    // Slave: word registers at adr[3:2]; ack_delay 0 means it never acks.
    int          stall_cfg = 0;
    int          ack_delay = 1;
    int          stall_cnt;
    int          ack_left;
    logic        sl_ack;
    logic [31:0] sl_rdat;
    logic [31:0] sl_regs [4];

    assign s_if.stall = s_if.stb && (stall_cnt < stall_cfg);
    assign s_if.ack   = sl_ack;
    assign s_if.dat_o = sl_rdat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_ack    <= 1'b0;
            ack_left  <= 0;
            stall_cnt <= 0;
            sl_rdat   <= 32'd0;
            for (int k = 0; k < 4; k++) sl_regs[k] <= 32'd0;
        end else begin
            sl_ack <= 1'b0;
            if (ack_left != 0) begin
                ack_left <= ack_left - 1;
                if (ack_left == 1) sl_ack <= 1'b1;
            end
            if (s_if.cyc && s_if.stb) begin
                if (stall_cnt < stall_cfg) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt <= 0;
                    sl_rdat   <= sl_regs[s_if.adr[3:2]];
                    if (s_if.we) sl_regs[s_if.adr[3:2]] <= s_if.dat_i;
                    if (ack_delay == 1)     sl_ack   <= 1'b1;
                    else if (ack_delay > 1) ack_left <= ack_delay - 1;
                end
            end
        end
    end

    int          total = 0;
    int          bad = 0;
    int          model_last;
    logic [31:0] mem_model [4];

    logic [31:0] t_adr [2];
    logic [31:0] t_dat [2];
    logic        t_we  [2];
    int          phase [2];
    int          nxt   [2];
    int          rem   [2];

    int          acks [2];
    logic [31:0] got_dat [2];
    int          spurious, stb_cycles, to_pulses, since_stb, ack_wait, hist_n;
    logic        ack_sack, ack_scyc, adr_moved, snap_bad, wait_we;
    logic [31:0] wait_dat, stb_adr, stb_dat;
    logic        stb_we;
    logic [7:0]  hist_code;
    logic [1:0]  prev_grant;
    int          order_q [$];

    task automatic drive(input int i);
        if (i == 0) begin
            m0_if.cyc = (phase[0] != 0); m0_if.stb = (phase[0] == 1);
            m0_if.adr = t_adr[0]; m0_if.dat_i = t_dat[0]; m0_if.we = t_we[0]; m0_if.sel = 4'hF;
        end else begin
            m1_if.cyc = (phase[1] != 0); m1_if.stb = (phase[1] == 1);
            m1_if.adr = t_adr[1]; m1_if.dat_i = t_dat[1]; m1_if.we = t_we[1]; m1_if.sel = 4'hF;
        end
    endtask

    // Runs n0/n1 back-to-back transactions per master; masters re-request
    // immediately after each ack, holding stb until accepted.
    task automatic run_txns(input int n0, input int n1, input int budget);
        logic        a, st;
        logic [31:0] d;
        bit          done;
        done = 0;
        acks[0] = 0; acks[1] = 0; got_dat[0] = 'x; got_dat[1] = 'x;
        spurious = 0; stb_cycles = 0; to_pulses = 0; since_stb = 0; ack_wait = 0;
        hist_n = 0; hist_code = 8'd0; prev_grant = 2'b00;
        ack_sack = 1'b0; ack_scyc = 1'b1; adr_moved = 1'b0; snap_bad = 1'b0;
        wait_we = 1'b0; wait_dat = 32'd0; stb_adr = 32'd0; stb_dat = 32'd0; stb_we = 1'b0;
        order_q.delete();
        rem[0] = n0; rem[1] = n1;
        @(posedge clk); #1;
        phase[0] = (n0 > 0) ? 1 : 0; phase[1] = (n1 > 0) ? 1 : 0;
        drive(0); drive(1);
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (s_if.stb) begin
                if (stb_cycles > 0 && since_stb == 0 && s_if.adr !== stb_adr) adr_moved = 1'b1;
                stb_cycles++; since_stb = 0;
                stb_adr = s_if.adr; stb_dat = s_if.dat_i; stb_we = s_if.we;
            end else begin
                since_stb++;
                if (s_if.cyc) begin
                    if (s_if.adr !== stb_adr || s_if.dat_i !== stb_dat || s_if.we !== stb_we) snap_bad = 1'b1;
                    wait_we = s_if.we; wait_dat = s_if.dat_i;
                end
            end
            if (timeout_o) to_pulses++;
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                hist_code = {hist_code[5:0], grant}; hist_n++;
            end
            prev_grant = grant;
            for (int i = 0; i < 2; i++) begin
                a  = (i == 0) ? m0_if.ack   : m1_if.ack;
                st = (i == 0) ? m0_if.stall : m1_if.stall;
                d  = (i == 0) ? m0_if.dat_o : m1_if.dat_o;
                nxt[i] = phase[i];
                if (a) begin
                    if (phase[i] != 2) spurious++;
                    else begin
                        acks[i]++; order_q.push_back(i); got_dat[i] = d;
                        ack_sack = s_if.ack; ack_scyc = s_if.cyc; ack_wait = since_stb;
                        rem[i]--; nxt[i] = (rem[i] > 0) ? 1 : 0;
                    end
                end else if (phase[i] == 1 && !st) begin
                    nxt[i] = 2;
                end
            end
            @(posedge clk); #1;
            phase[0] = nxt[0]; phase[1] = nxt[1];
            drive(0); drive(1);
            if (nxt[0] == 0 && nxt[1] == 0) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL run_budget: transactions still open after %0d cycles, want all acked", budget);
        end
    endtask

    task automatic set_txn(input int i, input logic [31:0] adr, input logic [31:0] dat, input logic we);
        t_adr[i] = adr; t_dat[i] = dat; t_we[i] = we;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total += 7;
        if (grant !== 2'b00)     begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
        if (s_if.cyc !== 1'b0)   begin bad++; $display("FAIL reset_scyc got=%b want=0", s_if.cyc); end
        if (s_if.stb !== 1'b0)   begin bad++; $display("FAIL reset_sstb got=%b want=0", s_if.stb); end
        if (m0_if.stall !== 1'b1) begin bad++; $display("FAIL reset_m0_stall got=%b want=1", m0_if.stall); end
        if (m1_if.stall !== 1'b1) begin bad++; $display("FAIL reset_m1_stall got=%b want=1", m1_if.stall); end
        if (m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b%b want=00", m0_if.ack, m1_if.ack); end
        if (timeout_o !== 1'b0)  begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_o); end
        @(negedge clk); rst_n = 1'b1;
        model_last = 1;
        for (int k = 0; k < 4; k++) mem_model[k] = 32'd0;
    endtask

    task automatic test_contention();
        set_txn(0, 32'h0, 32'h0, 1'b0);
        set_txn(1, 32'h4, 32'h0, 1'b0);
        run_txns(2, 2, 40);
        total += 4;
        if (hist_n != 4 || hist_code !== 8'b01_10_01_10) begin bad++; $display("FAIL contention_grants got=%b (n=%0d) want=01100110 (n=4)", hist_code, hist_n); end
        if (acks[0] != 2) begin bad++; $display("FAIL contention_m0_acks got=%0d want=2", acks[0]); end
        if (acks[1] != 2) begin bad++; $display("FAIL contention_m1_acks got=%0d want=2", acks[1]); end
        if (spurious != 0 || to_pulses != 0) begin bad++; $display("FAIL contention_extra got spurious=%0d to=%0d want 0 0", spurious, to_pulses); end
        model_last = 1;
    endtask

    task automatic test_write();
        set_txn(1, 32'h0, 32'h1, 1'b1);
        run_txns(0, 1, 20);
        mem_model[0] = 32'h1;
        model_last = 1;
        total += 5;
        if (acks[1] != 1 || acks[0] != 0) begin bad++; $display("FAIL write_acks got m0=%0d m1=%0d want 0 1", acks[0], acks[1]); end
        if (spurious != 0) begin bad++; $display("FAIL write_spurious got=%0d want=0", spurious); end
        if (wait_we !== 1'b1 || wait_dat !== 32'h1) begin bad++; $display("FAIL write_wait_bus got we=%b dat=%h want we=1 dat=1", wait_we, wait_dat); end
        if (snap_bad) begin bad++; $display("FAIL write_hold got=changed want=stable"); end
        if (sl_regs[0] !== 32'h1) begin bad++; $display("FAIL write_led got=%h want=1", sl_regs[0]); end
    endtask

    task automatic test_single_read();
        set_txn(0, 32'h0, 32'h0, 1'b0);
        run_txns(1, 0, 20);
        model_last = 0;
        @(negedge clk);
        total += 5;
        if (hist_n != 1 || hist_code[1:0] !== 2'b01) begin bad++; $display("FAIL read_grant got=%b (n=%0d) want=01", hist_code[1:0], hist_n); end
        if (stb_cycles != 1) begin bad++; $display("FAIL read_stb_cycles got=%0d want=1", stb_cycles); end
        if (got_dat[0] !== mem_model[0]) begin bad++; $display("FAIL read_data got=%h want=%h", got_dat[0], mem_model[0]); end
        if (ack_sack !== 1'b1 || ack_wait != 1) begin bad++; $display("FAIL read_ack_timing got sack=%b wait=%0d want 1 1", ack_sack, ack_wait); end
        if (grant !== 2'b00) begin bad++; $display("FAIL read_grant_idle got=%b want=00", grant); end
    endtask

    task automatic test_stall();
        stall_cfg = 3;
        set_txn(0, 32'h4, 32'h0, 1'b0);
        run_txns(1, 0, 30);
        stall_cfg = 0;
        model_last = 0;
        total += 3;
        if (stb_cycles != 4) begin bad++; $display("FAIL stall_stb_cycles got=%0d want=4", stb_cycles); end
        if (adr_moved || snap_bad) begin bad++; $display("FAIL stall_adr_stable got=moved want=stable"); end
        if (spurious != 0 || got_dat[0] !== mem_model[1]) begin bad++; $display("FAIL stall_result got spurious=%0d dat=%h want 0 %h", spurious, got_dat[0], mem_model[1]); end
    endtask

    task automatic test_timeout();
        ack_delay = 0;
        set_txn(1, 32'h8, 32'h0, 1'b0);
        run_txns(0, 1, 40);
        model_last = 1;
        total += 4;
        if (got_dat[1] !== TO_DATA) begin bad++; $display("FAIL timeout_data got=%h want=%h", got_dat[1], TO_DATA); end
        if (to_pulses != 1) begin bad++; $display("FAIL timeout_pulses got=%0d want=1", to_pulses); end
        if (ack_wait != 16) begin bad++; $display("FAIL timeout_wait got=%0d want=16", ack_wait); end
        if (ack_scyc !== 1'b0) begin bad++; $display("FAIL timeout_scyc got=%b want=0", ack_scyc); end
        ack_delay = 16;
        set_txn(0, 32'h0, 32'h0, 1'b0);
        run_txns(1, 0, 40);
        ack_delay = 1;
        model_last = 0;
        total += 3;
        if (got_dat[0] !== mem_model[0]) begin bad++; $display("FAIL late_ack_data got=%h want=%h", got_dat[0], mem_model[0]); end
        if (to_pulses != 0) begin bad++; $display("FAIL late_ack_pulses got=%0d want=0", to_pulses); end
        if (ack_wait != 16) begin bad++; $display("FAIL late_ack_wait got=%0d want=16", ack_wait); end
    endtask

    task automatic test_random();
        int          n0, n1, first, m, nsrv;
        logic [31:0] exp_dat [2];
        int          srv [2];
        for (int r = 0; r < 20; r++) begin
            n0 = $urandom_range(0, 1);
            n1 = (n0 != 0) ? $urandom_range(0, 1) : 1;
            for (int i = 0; i < 2; i++)
                set_txn(i, 32'($urandom_range(0, 3)) << 2, $urandom, 1'($urandom_range(0, 1)));
            ack_delay = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
            stall_cfg = $urandom_range(0, 2);
            if (n0 != 0 && n1 != 0) first = (model_last == 0) ? 1 : 0;
            else                    first = (n0 != 0) ? 0 : 1;
            nsrv = n0 + n1;
            srv[0] = first; srv[1] = 1 - first;
            exp_dat[0] = 32'd0; exp_dat[1] = 32'd0;
            for (int k = 0; k < nsrv; k++) begin
                m = srv[k];
                if (t_we[m]) mem_model[t_adr[m][3:2]] = t_dat[m];
                else exp_dat[m] = (ack_delay == 0) ? TO_DATA : mem_model[t_adr[m][3:2]];
                model_last = m;
            end
            run_txns(n0, n1, 80);
            total += 3;
            if (order_q.size() != nsrv || order_q[0] != first) begin bad++; $display("FAIL rand_order round=%0d got first=%0d n=%0d want first=%0d n=%0d", r, order_q[0], order_q.size(), first, nsrv); end
            if (to_pulses != ((ack_delay == 0) ? nsrv : 0)) begin bad++; $display("FAIL rand_timeouts round=%0d got=%0d want=%0d", r, to_pulses, (ack_delay == 0) ? nsrv : 0); end
            if ((n0 != 0 && !t_we[0] && got_dat[0] !== exp_dat[0]) || (n1 != 0 && !t_we[1] && got_dat[1] !== exp_dat[1]))
                begin bad++; $display("FAIL rand_data round=%0d got=%h/%h want=%h/%h", r, got_dat[0], got_dat[1], exp_dat[0], exp_dat[1]); end
        end
        stall_cfg = 0;
        ack_delay = 1;
    endtask

    task automatic test_reset_midop();
        bit seen;
        seen = 0;
        ack_delay = 0;
        set_txn(0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        phase[0] = 1; phase[1] = 0; drive(0); drive(1);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (s_if.cyc && !s_if.stb) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL midop_reach_wait got=not reached want=S_WAIT within 10 cycles"); end
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (s_if.cyc !== 1'b0) begin bad++; $display("FAIL midop_scyc got=%b want=0", s_if.cyc); end
        if (grant !== 2'b00 || m0_if.ack !== 1'b0) begin bad++; $display("FAIL midop_grant_ack got grant=%b ack=%b want 00 0", grant, m0_if.ack); end
        phase[0] = 0; drive(0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        ack_delay = 1;
        set_txn(1, 32'h4, 32'h0, 1'b0);
        run_txns(1, 1, 30);
        total += 2;
        if (hist_n != 2 || hist_code[3:0] !== 4'b0110) begin bad++; $display("FAIL midop_regrant got=%b (n=%0d) want=0110 (n=2)", hist_code[3:0], hist_n); end
        if (spurious != 0) begin bad++; $display("FAIL midop_spurious got=%0d want=0", spurious); end
    endtask

    initial begin
        phase[0] = 0; phase[1] = 0;
        set_txn(0, 32'h0, 32'h0, 1'b0);
        set_txn(1, 32'h0, 32'h0, 1'b0);
        drive(0); drive(1);
        test_reset();
        test_contention();
        test_write();
        test_single_read();
        test_stall();
        test_timeout();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation exceeded 500000 time units");
        $fatal(1);
    end
endmodule
